// File: rtl/tpu_pkg.sv
// Shared TPU definitions: element type, drain FSM states and small helpers
// used by the operand-feed and result-drain logic.
package tpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        EMIT,
        DONE
    } drain_state_t;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] elem_t;

    // Requested row count limited to the physical array height.
    function automatic logic [7:0] clamp_rows(input logic [7:0] req, input logic [7:0] limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/deskew_delay.sv
// Fixed-depth shift register that realigns one column of the skewed drain bus.
// A depth of zero collapses to a plain wire.
module deskew_delay
    import tpu_pkg::*;
#(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
            assign dout = din;
        end else begin : g_shift
            logic [DATA_WIDTH-1:0] stage [0:DEPTH-1];

            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value, so the chain shifts by exactly one per clock.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_drain.sv
// Receive end of the skewed systolic path: deskews the array's down_out bus,
// restores row order into a buffer and streams rows out over a valid/ready port.
module systolic_drain
    import tpu_pkg::*;
#(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            size_row_A,
    input  logic [DATA_WIDTH-1:0] down_in [0:COLUMN_NUMBER-1],
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [7:0]            res_row,
    output logic [DATA_WIDTH-1:0] res_data [0:COLUMN_NUMBER-1],
    output logic                  busy,
    output logic                  done
);

    localparam int         ROW_IDX_W = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
    localparam logic [7:0] ROW_MAX   = 8'(ROW_NUMBER);
    localparam logic [7:0] SKEW_LAST = 8'(COLUMN_NUMBER - 1);

    drain_state_t state, state_n;

    logic [7:0]            rows_q, skew_cnt, drain_cnt, emit_row;
    logic [DATA_WIDTH-1:0] aligned [0:COLUMN_NUMBER-1];
    logic [DATA_WIDTH-1:0] buffer  [0:ROW_NUMBER-1][0:COLUMN_NUMBER-1];
    logic                  capture, last_capture, handshake, last_handshake;
    logic [ROW_IDX_W-1:0]  wr_idx, rd_idx;

    // Column j arrives j cycles late; delaying it by COLUMN_NUMBER-1-j lines all columns up.
    generate
        for (genvar j = 0; j < COLUMN_NUMBER; j++) begin : g_col
            deskew_delay #(
                .DEPTH      (COLUMN_NUMBER - 1 - j),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_delay (
                .clk   (clk),
                .reset (reset),
                .din   (down_in[j]),
                .dout  (aligned[j])
            );
        end
    endgenerate

    assign capture        = (state == DRAIN) && (skew_cnt == SKEW_LAST);
    assign last_capture   = capture && (drain_cnt == rows_q - 8'd1);
    assign handshake      = res_valid && res_ready;
    assign last_handshake = handshake && (emit_row == rows_q - 8'd1);
    // The bottom row drains first, so item k lands in row rows-1-k.
    assign wr_idx         = ROW_IDX_W'(rows_q - 8'd1 - drain_cnt);
    assign rd_idx         = ROW_IDX_W'(emit_row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // NOTE: state_n takes a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = (size_row_A == 8'd0) ? DONE : DRAIN;
            DRAIN: if (last_capture) state_n = EMIT;
            EMIT:  if (last_handshake) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q    <= '0;
            skew_cnt  <= '0;
            drain_cnt <= '0;
            emit_row  <= '0;
        end else if (state == IDLE && start) begin
            rows_q    <= clamp_rows(size_row_A, ROW_MAX);
            skew_cnt  <= '0;
            drain_cnt <= '0;
            emit_row  <= '0;
        end else if (state == DRAIN) begin
            if (capture) drain_cnt <= drain_cnt + 8'd1;
            else         skew_cnt  <= skew_cnt + 8'd1;
        end else if (handshake) begin
            emit_row <= emit_row + 8'd1;
        end
    end

    // NOTE: the result buffer has no reset; it is only read while res_valid is high,
    // and every such row has been written during the preceding drain.
    always_ff @(posedge clk) begin
        if (capture) buffer[wr_idx] <= aligned;
    end

    assign res_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign res_row   = res_valid ? emit_row : 8'd0;

    always_comb begin
        for (int j = 0; j < COLUMN_NUMBER; j++) begin
            res_data[j] = res_valid ? buffer[rd_idx][j] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: random skewed drains against a row-order
// model, with timing, backpressure, boundary-count and reset/start checks.
module tb_systolic_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;

    typedef struct {
        int          row;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    size_row_A;
    logic [DW-1:0] down_in [0:COLS-1];
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_row;
    logic [DW-1:0] res_data [0:COLS-1];
    logic          busy;
    logic          done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   first_valid_rel = -1;
    int   done_rel        = -1;
    int   done_cnt        = 0;
    exp_t sb [$];

    systolic_drain #(
        .ROW_NUMBER    (ROWS),
        .COLUMN_NUMBER (COLS),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .size_row_A (size_row_A),
        .down_in    (down_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_row    (res_row),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    function automatic logic [31:0] pack(input logic [DW-1:0] d [0:COLS-1]);
        logic [31:0] p;
        p = '0;
        for (int j = 0; j < COLS; j++) p[j*DW +: DW] = d[j];
        return p;
    endfunction

    // Monitor: every presented row must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (res_valid) begin
                    if (first_valid_rel < 0) first_valid_rel = cyc - t0;
                    if (sb.size() == 0) begin
                        check("unexpected_row", {63'b0, res_valid}, 64'd0);
                    end else begin
                        e = sb[0];
                        check("res_row", {56'b0, res_row}, 64'(e.row));
                        check("res_data", {32'b0, pack(res_data)}, {32'b0, e.data});
                        if (res_ready) void'(sb.pop_front());
                    end
                end else begin
                    check("idle_data_zero", {32'b0, pack(res_data)}, 64'd0);
                end
                if (done) begin
                    done_cnt++;
                    if (done_rel < 0) done_rel = cyc - t0;
                end
            end
        end
    end

    // One drain/emit transaction. Cycle 0 is the start cycle.
    task automatic run_seq(input int size, input bit pattern, input bit rand_ready,
                           input int stall_lo, input int stall_hi,
                           input int extra_start, input bit timed);
        logic [DW-1:0] mat [0:ROWS-1][0:COLS-1];
        int            rows, exp_done, c, k;
        bit            finished;
        exp_t          e;

        rows = (size > ROWS) ? ROWS : size;
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < COLS; j++)
                mat[r][j] = pattern ? 8'(16*r + j) : 8'($urandom);
        for (int r = 0; r < rows; r++) begin
            e.row  = r;
            e.data = '0;
            for (int j = 0; j < COLS; j++) e.data[j*DW +: DW] = mat[r][j];
            sb.push_back(e);
        end
        exp_done = (rows == 0) ? 1 : 2*rows + COLS + (stall_hi - stall_lo);

        @(posedge clk); #1;
        t0 = cyc;
        first_valid_rel = -1;
        done_rel = -1;
        start = 1'b1;
        size_row_A = 8'(size);
        for (int j = 0; j < COLS; j++) down_in[j] = 8'hFF;
        res_ready = 1'b1;
        c = 0;
        finished = 1'b0;
        while (!finished) begin
            @(negedge clk);
            if (c == 1 && rows > 0) check("busy_in_drain", {63'b0, busy}, 64'd1);
            if (done_rel >= 0 && c == done_rel + 1) begin
                check("busy_after_done", {63'b0, busy}, 64'd0);
                finished = 1'b1;
            end else if (c >= 300) begin
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
                c++;
                start = (c == extra_start);
                size_row_A = start ? 8'd1 : 8'(size);
                // Column j carries drain item k (result row rows-1-k) at cycle 1+k+j.
                for (int j = 0; j < COLS; j++) begin
                    k = c - 1 - j;
                    down_in[j] = (k >= 0 && k < rows) ? mat[rows-1-k][j] : 8'hFF;
                end
                if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
                else            res_ready = !(c >= stall_lo && c < stall_hi);
            end
        end
        start = 1'b0;
        res_ready = 1'b1;

        check("done_seen", {63'b0, done_rel >= 0}, 64'd1);
        check("rows_outstanding", 64'(sb.size()), 64'd0);
        check("first_valid_cycle", 64'(first_valid_rel), (rows == 0) ? -64'sd1 : 64'(rows + COLS));
        if (timed) check("done_cycle", 64'(done_rel), 64'(exp_done));
        sb.delete();
    endtask

    task automatic reset_abort();
        int dc;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        size_row_A = 8'd4;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            for (int j = 0; j < COLS; j++) down_in[j] = 8'($urandom);
        end
        check("busy_before_abort", {63'b0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_valid", {63'b0, res_valid}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_row", {56'b0, res_row}, 64'd0);
        check("abort_data", {32'b0, pack(res_data)}, 64'd0);
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt), 64'(dc));
        check("idle_after_abort", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        size_row_A = 8'd0;
        res_ready = 1'b1;
        for (int j = 0; j < COLS; j++) down_in[j] = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'b0, res_valid}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_row", {56'b0, res_row}, 64'd0);
        check("rst_data", {32'b0, pack(res_data)}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        run_seq(4, 1'b1, 1'b0, 0, 0, -1, 1'b1);   // full matrix, 16*r+j
        run_seq(2, 1'b0, 1'b0, 0, 0, -1, 1'b1);   // partial
        run_seq(4, 1'b0, 1'b0, 9, 14, -1, 1'b1);  // 5-cycle stall on row 1
        run_seq(0, 1'b0, 1'b0, 0, 0, -1, 1'b1);   // empty
        run_seq(9, 1'b0, 1'b0, 0, 0, -1, 1'b1);   // clamped to 4 rows
        reset_abort();
        run_seq(3, 1'b0, 1'b0, 0, 0, -1, 1'b1);   // recovery after abort
        run_seq(4, 1'b0, 1'b0, 0, 0, 9, 1'b1);    // start during EMIT
        run_seq(4, 1'b0, 1'b0, 0, 0, 12, 1'b1);   // start on the done cycle
        for (int i = 0; i < 8; i++)
            run_seq(int'($urandom_range(0, 6)), 1'b0, 1'b1, 0, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
